tc_rom_loader: RTL and testbench

TC_ROM_LOADER -- requirements
Module: tc_rom_loader

---
 rtl/tc_rom_loader.sv | 141 ++++++++++++++
 tb/tb_tc_rom_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tc_rom_loader.sv
// Byte-stream to memory-word loader: packs incoming bytes little-endian into
// BIT_WIDTH-wide words and writes them to consecutive addresses of a RAM save port.
module tc_rom_loader #(
    parameter int    UUID      = 0,
    parameter string NAME      = "",
    parameter int    BIT_WIDTH = 16,
    parameter int    BIT_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    input  logic                 byte_last,
    output logic                 byte_ready,
    output logic                 mem_save,
    output logic [15:0]          mem_address,
    output logic [BIT_WIDTH-1:0] mem_in,
    output logic                 busy,
    output logic                 done,
    output logic                 truncated,
    output logic [15:0]          words_written
);

    localparam int BPW = BIT_WIDTH / 8;
    localparam int KW  = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          addr_q, addr_d;
    logic [KW-1:0]        k_q, k_d;
    logic [BIT_WIDTH-1:0] buf_q, buf_d;
    logic [BIT_WIDTH-1:0] buf_fill;
    logic                 last_q, last_d;
    logic                 trunc_q, trunc_d;
    logic [15:0]          ww_q, ww_d;

    logic                 accept;
    logic [16:0]          addr_inc;

    assign accept   = (state_q == COLLECT) && byte_valid;
    assign addr_inc = {1'b0, addr_q} + 17'd1;

    // Each byte lane loads only when the byte index points at it.
    generate
        for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
            assign buf_fill[gi*8 +: 8] = (accept && (k_q == KW'(gi))) ? byte_data
                                                                      : buf_q[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        k_d     = k_q;
        buf_d   = buf_q;
        last_d  = last_q;
        trunc_d = trunc_q;
        ww_d    = ww_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = COLLECT;
                    addr_d  = '0;
                    k_d     = '0;
                    buf_d   = '0;
                    last_d  = 1'b0;
                    trunc_d = 1'b0;
                    ww_d    = '0;
                end
            end
            COLLECT: begin
                if (accept) begin
                    buf_d = buf_fill;
                    if ((k_q == KW'(BPW - 1)) || byte_last) begin
                        state_d = WRITE;
                        last_d  = byte_last;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            WRITE: begin
                ww_d  = ww_q + 16'd1;
                k_d   = '0;
                buf_d = '0;
                // Address saturates at the last word so it never points past the memory.
                if (addr_inc < 17'(BIT_DEPTH)) begin
                    addr_d = addr_inc[15:0];
                end
                if (last_q) begin
                    state_d = DONE;
                    trunc_d = 1'b0;
                end else if (addr_inc == 17'(BIT_DEPTH)) begin
                    state_d = DONE;
                    trunc_d = 1'b1;
                end else begin
                    state_d = COLLECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            k_q     <= '0;
            buf_q   <= '0;
            last_q  <= 1'b0;
            trunc_q <= 1'b0;
            ww_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            k_q     <= k_d;
            buf_q   <= buf_d;
            last_q  <= last_d;
            trunc_q <= trunc_d;
            ww_q    <= ww_d;
        end
    end

    // Outputs decode straight from flops, so they are stable for the whole cycle.
    assign byte_ready    = (state_q == COLLECT);
    assign mem_save      = (state_q == WRITE);
    assign mem_address   = mem_save ? addr_q : 16'd0;
    assign mem_in        = mem_save ? buf_q : '0;
    assign busy          = (state_q == COLLECT) || (state_q == WRITE);
    assign done          = (state_q == DONE);
    assign truncated     = trunc_q;
    assign words_written = ww_q;

endmodule

// File: tb/tb_tc_rom_loader.sv
// Self-checking bench for tc_rom_loader: per-cycle vector table on a 16-bit
// instance, plus hand-written sessions on 32-bit and 8-bit/depth-4 instances.
module tb_tc_rom_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // ---------------- 16-bit instance ----------------
    logic        start16, valid16, last16;
    logic [7:0]  data16;
    logic        ready16, save16, busy16, done16, trunc16;
    logic [15:0] addr16, din16, ww16;

    tc_rom_loader #(.UUID(1), .NAME("w16"), .BIT_WIDTH(16), .BIT_DEPTH(256)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .byte_valid(valid16), .byte_data(data16),
        .byte_last(last16), .byte_ready(ready16), .mem_save(save16), .mem_address(addr16),
        .mem_in(din16), .busy(busy16), .done(done16), .truncated(trunc16), .words_written(ww16));

    // ---------------- 32-bit instance ----------------
    logic        start32, valid32, last32;
    logic [7:0]  data32;
    logic        ready32, save32, busy32, done32, trunc32;
    logic [15:0] addr32, ww32;
    logic [31:0] din32;

    tc_rom_loader #(.UUID(2), .NAME("w32"), .BIT_WIDTH(32), .BIT_DEPTH(256)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .byte_valid(valid32), .byte_data(data32),
        .byte_last(last32), .byte_ready(ready32), .mem_save(save32), .mem_address(addr32),
        .mem_in(din32), .busy(busy32), .done(done32), .truncated(trunc32), .words_written(ww32));

    // ---------------- 8-bit, depth-4 instance ----------------
    logic        start8, valid8, last8;
    logic [7:0]  data8;
    logic        ready8, save8, busy8, done8, trunc8;
    logic [15:0] addr8, ww8;
    logic [7:0]  din8;

    tc_rom_loader #(.UUID(3), .NAME("w8"), .BIT_WIDTH(8), .BIT_DEPTH(4)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .byte_valid(valid8), .byte_data(data8),
        .byte_last(last8), .byte_ready(ready8), .mem_save(save8), .mem_address(addr8),
        .mem_in(din8), .busy(busy8), .done(done8), .truncated(trunc8), .words_written(ww8));

    typedef struct {
        logic        rst, start, valid;
        logic [7:0]  data;
        logic        last;
        logic        ready, save;
        logic [15:0] addr, din;
        logic        busy, done, trunc;
        logic [15:0] ww;
    } vec_t;

    function automatic vec_t mk(input logic r, s, v, input logic [7:0] d, input logic l,
                                input logic e_rdy, e_sv, input logic [15:0] e_ad, e_din,
                                input logic e_bsy, e_dn, e_tr, input logic [15:0] e_ww);
        vec_t t;
        t.rst = r;  t.start = s;  t.valid = v;  t.data = d;  t.last = l;
        t.ready = e_rdy;  t.save = e_sv;  t.addr = e_ad;  t.din = e_din;
        t.busy = e_bsy;  t.done = e_dn;  t.trunc = e_tr;  t.ww = e_ww;
        return t;
    endfunction

    vec_t vecs[17];

    // Drives a handshaked byte stream into the 8-bit instance until DONE or budget runs out.
    task automatic run8(input int n, input logic [7:0] base, input bit with_last,
                        output int nacc, output int nwr);
        int  idx = 0;
        bit  acc;
        nwr = 0;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int c = 0; c < 40 && !done8; c++) begin
            valid8 = (idx < n);
            data8  = base + 8'(idx);
            last8  = with_last && (idx == n - 1);
            acc    = ready8 && valid8;
            @(posedge clk); #1;
            if (acc) idx++;
            if (save8) begin
                chk($sformatf("w8_addr%0d", nwr), addr8, 64'(nwr));
                chk($sformatf("w8_data%0d", nwr), din8, 64'(base + 8'(nwr)));
                nwr++;
            end
        end
        valid8 = 1'b0;
        last8  = 1'b0;
        nacc   = idx;
        chk("w8_reached_done", done8, 1);
    endtask

    initial begin
        int nacc, nwr;
        rst = 1'b1;
        {start16, valid16, last16, data16} = '0;
        {start32, valid32, last32, data32} = '0;
        {start8, valid8, last8, data8}     = '0;

        //           rst start vld data  last  rdy sv addr  din    bsy dn tr ww
        vecs[0]  = mk(1, 0, 0, 8'h00, 0,   0, 0, 16'd0, 16'h0000, 0, 0, 0, 16'd0);
        vecs[1]  = mk(0, 1, 0, 8'h00, 0,   1, 0, 16'd0, 16'h0000, 1, 0, 0, 16'd0);
        vecs[2]  = mk(0, 0, 1, 8'h34, 0,   1, 0, 16'd0, 16'h0000, 1, 0, 0, 16'd0);
        vecs[3]  = mk(0, 0, 0, 8'hEE, 0,   1, 0, 16'd0, 16'h0000, 1, 0, 0, 16'd0);
        vecs[4]  = mk(0, 0, 1, 8'h12, 0,   0, 1, 16'd0, 16'h1234, 1, 0, 0, 16'd0);
        vecs[5]  = mk(0, 1, 1, 8'h99, 0,   1, 0, 16'd0, 16'h0000, 1, 0, 0, 16'd1);
        vecs[6]  = mk(0, 1, 1, 8'h78, 0,   1, 0, 16'd0, 16'h0000, 1, 0, 0, 16'd1);
        vecs[7]  = mk(0, 0, 1, 8'h56, 1,   0, 1, 16'd1, 16'h5678, 1, 0, 0, 16'd1);
        vecs[8]  = mk(0, 0, 0, 8'h00, 0,   0, 0, 16'd0, 16'h0000, 0, 1, 0, 16'd2);
        vecs[9]  = mk(0, 0, 1, 8'h11, 0,   0, 0, 16'd0, 16'h0000, 0, 1, 0, 16'd2);
        vecs[10] = mk(0, 1, 0, 8'h00, 0,   1, 0, 16'd0, 16'h0000, 1, 0, 0, 16'd0);
        vecs[11] = mk(0, 0, 1, 8'hAB, 0,   1, 0, 16'd0, 16'h0000, 1, 0, 0, 16'd0);
        vecs[12] = mk(1, 0, 0, 8'h00, 0,   0, 0, 16'd0, 16'h0000, 0, 0, 0, 16'd0);
        vecs[13] = mk(0, 1, 0, 8'h00, 0,   1, 0, 16'd0, 16'h0000, 1, 0, 0, 16'd0);
        vecs[14] = mk(0, 0, 1, 8'hCD, 1,   0, 1, 16'd0, 16'h00CD, 1, 0, 0, 16'd0);
        vecs[15] = mk(0, 0, 0, 8'h00, 0,   0, 0, 16'd0, 16'h0000, 0, 1, 0, 16'd1);
        vecs[16] = mk(1, 1, 0, 8'h00, 0,   0, 0, 16'd0, 16'h0000, 0, 0, 0, 16'd0);

        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) begin
            rst     = vecs[i].rst;
            start16 = vecs[i].start;
            valid16 = vecs[i].valid;
            data16  = vecs[i].data;
            last16  = vecs[i].last;
            @(posedge clk); #1;
            chk($sformatf("v%0d_ready", i), ready16, vecs[i].ready);
            chk($sformatf("v%0d_save",  i), save16,  vecs[i].save);
            chk($sformatf("v%0d_addr",  i), addr16,  vecs[i].addr);
            chk($sformatf("v%0d_din",   i), din16,   vecs[i].din);
            chk($sformatf("v%0d_busy",  i), busy16,  vecs[i].busy);
            chk($sformatf("v%0d_done",  i), done16,  vecs[i].done);
            chk($sformatf("v%0d_trunc", i), trunc16, vecs[i].trunc);
            chk($sformatf("v%0d_ww",    i), ww16,    vecs[i].ww);
        end
        rst = 1'b0;
        {start16, valid16, last16, data16} = '0;
        @(posedge clk); #1;

        // 32-bit partial word: three bytes then last, upper byte zero-filled
        start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        chk("w32_busy", busy32, 1);
        valid32 = 1'b1;
        data32 = 8'hAA; @(posedge clk); #1;
        data32 = 8'hBB; @(posedge clk); #1;
        data32 = 8'hCC; last32 = 1'b1; @(posedge clk); #1;
        valid32 = 1'b0; last32 = 1'b0;
        chk("w32_save", save32, 1);
        chk("w32_addr", addr32, 0);
        chk("w32_data", din32, 32'h00CCBBAA);
        @(posedge clk); #1;
        chk("w32_save_off", save32, 0);
        chk("w32_done", done32, 1);
        chk("w32_ww", ww32, 1);
        chk("w32_trunc", trunc32, 0);

        // Depth limit without last: six bytes offered, only four taken
        run8(6, 8'h01, 1'b0, nacc, nwr);
        chk("w8a_accepted", nacc, 4);
        chk("w8a_writes", nwr, 4);
        chk("w8a_trunc", trunc8, 1);
        chk("w8a_ready", ready8, 0);
        chk("w8a_ww", ww8, 4);
        @(posedge clk); #1;
        chk("w8a_hold_done", done8, 1);
        chk("w8a_hold_save", save8, 0);

        // Last coincides with depth limit: last wins, not truncated
        run8(4, 8'h10, 1'b1, nacc, nwr);
        chk("w8b_accepted", nacc, 4);
        chk("w8b_writes", nwr, 4);
        chk("w8b_trunc", trunc8, 0);
        chk("w8b_ww", ww8, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
